topk_result_streamer: RTL and testbench
=======================================

# topk_result_streamer

Drains the wide, fully sorted vector produced by the bitonic sorting network and streams its top-K elements out one per cycle over a valid/ready interface. Sits directly behind the sorter's `y`/`o_valid` outputs, which carry no backpressure. The block therefore holds up to two result vectors in a ping-pong buffer and flags any vector it has to drop. Downstream consumers, such as the top-k merge logic and the result writer, see a simple element stream with rank and last markers.

## Interface
- `LOG_INPUT_NUM`, 4: vector holds N = 2**LOG_INPUT_NUM elements.
- `DATA_WIDTH`, 32: element width (fp32 bit pattern, passed through untouched).
- `ASCENDING`, 1: must match the sorter. 1 means the largest element is in lane N-1; 0 means it is in lane 0.
- `TOPK`, 4: elements emitted per vector. Legal range is 1..N; elaboration error otherwise.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  one-cycle pulse: `x` holds a sorted vector.
- `x`  in  DATA_WIDTH*N  sorted vector; lane i is `x[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]`.
- `i_ready`  out  1  registered; 1 while fewer than 2 vectors are buffered. Advisory only.
- `o_valid`  out  1  element available.
- `o_ready`  in  1  consumer accepts the element when `o_valid & o_ready`.
- `o_data`  out  DATA_WIDTH  current element.
- `o_rank`  out  LOG_INPUT_NUM  rank of `o_data`; 0 is the best, i.e. the largest element.
- `o_last`  out  1  high with rank TOPK-1.
- `overflow`  out  1  sticky; set when an input vector is dropped, cleared only by `rst`.

## Operation
- Buffer: 2 vector slots with a write pointer, a read pointer and a 2-bit count (0, 1 or 2). Only the top TOPK lanes of each vector are stored.
- Lane mapping:
  - rank r maps to lane N-1-r when ASCENDING=1;
  - rank r maps to lane r when ASCENDING=0.
- Write: on `i_valid`, the vector is stored at the write pointer if count < 2. It is also stored if count == 2 and the final element of the head vector is handshaked in the same cycle (`o_valid & o_ready & o_last`).
- Drop: in any other `i_valid` case with count == 2, the vector is discarded, `overflow` is set, and buffer state is unchanged.
- Read: the output is the head slot indexed by a rank counter. A handshake advances the rank. A handshake with `o_last` resets the rank to 0, advances the read pointer and decrements count.
- Simultaneous write and last-read: count stays the same and both pointers advance.
- FSM, with the rank counter as sub-state:
  - IDLE (count == 0): `o_valid` = 0. Goes to STREAM on a write.
  - STREAM (count ≥ 1): `o_valid` = 1. Goes to IDLE on a last-handshake with no write while count == 1; otherwise stays in STREAM.
- Stall: while `o_valid & !o_ready`, `o_data`, `o_rank` and `o_last` hold stable. `o_valid` never drops without a handshake.
- TOPK == 1: every element is `o_last`, and each vector occupies exactly one output handshake.

## Timing
- Reset values: `o_valid` 0, `o_data` 0, `o_rank` 0, `o_last` 0, `overflow` 0, `i_ready` 1. All buffer slots, pointers, count and rank are 0.
- Latency: a vector captured at edge T into an empty buffer gives `o_valid` = 1 with rank 0 from T+1.
- Output ports are driven from registers only: the slot registers, the rank counter and the FSM state, through the rank mux. There is no combinational path from `i_valid` or `x`.
- `o_ready` affects state only at clock edges. It has no combinational path to any output.
- Throughput: 1 element/cycle with `o_ready` held high. Sustained input rate without drops is 1 vector per TOPK cycles.
- `i_ready` reflects the count after the previous edge.
- `rst` asserted mid-stream: all state clears immediately. Buffered vectors are lost and `overflow` clears.

## Structure
- Shared package `topk_pkg`:
  - localparam N derived from LOG_INPUT_NUM;
  - function `rank_to_lane(rank, ascending, n)`;
  - element typedef of DATA_WIDTH bits.
- One sub-module, `topk_vec_buf2`: the 2-slot vector buffer with count and pointers, holding TOPK×DATA_WIDTH per slot. The top level holds the FSM, the rank counter, output muxing and overflow.

## Test plan
All scenarios use N=16 and lane i = 100+i unless stated.
1. Single vector, ASCENDING=1, TOPK=4, `o_ready`=1 → from T+1, outputs (115,r0), (114,r1), (113,r2), (112,r3,`o_last`), then `o_valid` = 0.
2. Same vector with ASCENDING=0 → outputs 100, 101, 102, 103 with ranks 0..3.
3. Backpressure: `o_ready` low for 3 cycles at rank 1 → `o_data` holds 114 and `o_rank` holds 1. The stream resumes in order with no loss or duplicate.
4. Overflow:
   - Three `i_valid` pulses in consecutive cycles (vectors A, B, C) with `o_ready`=0 → A and B are streamed, C is dropped, `overflow` = 1 and stays set.
   - Repeat with C arriving on A's last-handshake cycle → C is accepted and `overflow` stays 0.
5. Back-to-back: vectors every 4 cycles, TOPK=4, `o_ready`=1 → `o_valid` continuously high, 12 elements in order, `overflow` 0. Also TOPK=1: `o_last` on every element.
6. Assert `rst` mid-stream at rank 2 → all outputs return to reset values the same cycle. A fresh vector afterwards streams from rank 0.

Source files
------------

// File: rtl/topk_pkg.sv
// Shared types and helpers for the top-K result streamer.
package topk_pkg;

    localparam int unsigned LOG_INPUT_NUM_DEF = 4;
    localparam int unsigned N                 = 2 ** LOG_INPUT_NUM_DEF;
    localparam int unsigned ELEM_WIDTH        = 32;

    typedef logic [ELEM_WIDTH-1:0] elem_t;

    // Sorted-vector lane holding a given rank (rank 0 = largest element).
    function automatic int unsigned rank_to_lane(input int unsigned rank,
                                                 input bit          ascending,
                                                 input int unsigned n);
        return ascending ? (n - 1 - rank) : rank;
    endfunction

endpackage

// File: rtl/topk_vec_buf2.sv
// Two-slot ping-pong buffer of rank-ordered top-K vectors with occupancy count.
module topk_vec_buf2
    import topk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TOPK       = 4,
    parameter int unsigned IDX_W      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [TOPK*DATA_WIDTH-1:0] i_wr_data,
    input  logic                       i_rd_pop,
    input  logic [IDX_W-1:0]           i_rd_idx,
    output logic [DATA_WIDTH-1:0]      o_rd_data,
    output logic [1:0]                 o_count
);

    logic [DATA_WIDTH-1:0] r_slot [2][TOPK];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < int'(TOPK); k++) begin
                    r_slot[s][k] <= '0;
                end
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_wr_en) begin
                for (int k = 0; k < int'(TOPK); k++) begin
                    r_slot[r_wr_ptr][k] <= i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_rd_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_wr_en, i_rd_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_slot[r_rd_ptr][i_rd_idx];
    assign o_count   = r_count;

endmodule

// File: rtl/topk_result_streamer.sv
// Streams the top-K elements of each sorted vector, best first, over valid/ready.
module topk_result_streamer #(
    parameter int unsigned LOG_INPUT_NUM = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter bit          ASCENDING     = 1'b1,
    parameter int unsigned TOPK          = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_valid,
    input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  x,
    output logic                                      i_ready,
    output logic                                      o_valid,
    input  logic                                      o_ready,
    output logic [DATA_WIDTH-1:0]                     o_data,
    output logic [LOG_INPUT_NUM-1:0]                  o_rank,
    output logic                                      o_last,
    output logic                                      overflow
);
    import topk_pkg::*;

    localparam int unsigned N_LANES = 2 ** LOG_INPUT_NUM;
    localparam int unsigned IDX_W   = (TOPK > 1) ? $clog2(TOPK) : 1;

    if (TOPK < 1 || TOPK > N_LANES) begin : g_bad_topk
        $error("topk_result_streamer: TOPK must be within 1..2**LOG_INPUT_NUM");
    end

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t                     r_state;
    logic [LOG_INPUT_NUM-1:0]   r_rank;
    logic                       r_overflow;
    logic                       r_i_ready;

    logic [TOPK*DATA_WIDTH-1:0] w_wr_data;
    logic [DATA_WIDTH-1:0]      w_rd_data;
    logic [1:0]                 w_count;
    logic [1:0]                 w_count_nxt;
    logic                       w_valid;
    logic                       w_last;
    logic                       w_hs;
    logic                       w_pop;
    logic                       w_wr;
    logic                       w_drop;
    logic                       w_unused_x;

    // Keep only the top TOPK lanes, reordered so index == rank.
    for (genvar r = 0; r < TOPK; r++) begin : g_lane
        localparam int unsigned LANE = rank_to_lane(r, ASCENDING, N_LANES);
        assign w_wr_data[r*DATA_WIDTH +: DATA_WIDTH] = x[LANE*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_unused_x = ^x;

    assign w_valid = (r_state == S_STREAM);
    assign w_last  = w_valid && (r_rank == LOG_INPUT_NUM'(TOPK - 1));
    assign w_hs    = w_valid && o_ready;
    assign w_pop   = w_hs && w_last;
    // A full buffer still accepts a vector when the head is retiring this cycle.
    assign w_wr    = i_valid && ((w_count != 2'd2) || w_pop);
    assign w_drop  = i_valid && !w_wr;

    always_comb begin
        w_count_nxt = w_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = w_count + 2'd1;
        end else if (!w_wr && w_pop) begin
            w_count_nxt = w_count - 2'd1;
        end
    end

    topk_vec_buf2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .TOPK       (TOPK),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr),
        .i_wr_data (w_wr_data),
        .i_rd_pop  (w_pop),
        .i_rd_idx  (IDX_W'(r_rank)),
        .o_rd_data (w_rd_data),
        .o_count   (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rank     <= '0;
            r_overflow <= 1'b0;
            r_i_ready  <= 1'b1;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_i_ready <= (w_count_nxt != 2'd2);
            if (w_hs) begin
                r_rank <= w_last ? '0 : r_rank + LOG_INPUT_NUM'(1);
            end
            if (r_state == S_IDLE) begin
                if (w_wr) begin
                    r_state <= S_STREAM;
                end
            end else begin
                if (w_pop && !w_wr && (w_count == 2'd1)) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign o_valid  = w_valid;
    assign o_data   = w_rd_data;
    assign o_rank   = r_rank;
    assign o_last   = w_last;
    assign overflow = r_overflow;
    assign i_ready  = r_i_ready;

endmodule

// File: tb/tb_topk_result_streamer.sv
// Directed bench for topk_result_streamer: ordering, backpressure, overflow, reset.
module tb_topk_result_streamer;
    import topk_pkg::*;

    localparam int unsigned VW = N * ELEM_WIDTH;

    logic          clk;
    logic          rst;
    logic [VW-1:0] x;

    logic va, ra, a_iready, a_valid, a_last, a_ovf;
    logic vd, rd, d_iready, d_valid, d_last, d_ovf;
    logic vk, rk, k_iready, k_valid, k_last, k_ovf;
    elem_t       a_data, d_data, k_data;
    logic [3:0]  a_rank, d_rank, k_rank;

    int n_pass;
    int n_total;

    topk_result_streamer #(.LOG_INPUT_NUM(4), .DATA_WIDTH(32), .ASCENDING(1'b1), .TOPK(4)) u_a (
        .clk(clk), .rst(rst), .i_valid(va), .x(x), .i_ready(a_iready), .o_valid(a_valid),
        .o_ready(ra), .o_data(a_data), .o_rank(a_rank), .o_last(a_last), .overflow(a_ovf));

    topk_result_streamer #(.LOG_INPUT_NUM(4), .DATA_WIDTH(32), .ASCENDING(1'b0), .TOPK(4)) u_d (
        .clk(clk), .rst(rst), .i_valid(vd), .x(x), .i_ready(d_iready), .o_valid(d_valid),
        .o_ready(rd), .o_data(d_data), .o_rank(d_rank), .o_last(d_last), .overflow(d_ovf));

    topk_result_streamer #(.LOG_INPUT_NUM(4), .DATA_WIDTH(32), .ASCENDING(1'b1), .TOPK(1)) u_k (
        .clk(clk), .rst(rst), .i_valid(vk), .x(x), .i_ready(k_iready), .o_valid(k_valid),
        .o_ready(rk), .o_data(k_data), .o_rank(k_rank), .o_last(k_last), .overflow(k_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane i of the vector carries base + i.
    function automatic logic [VW-1:0] vec(input int base);
        logic [VW-1:0] v;
        for (int i = 0; i < int'(N); i++) v[i*ELEM_WIDTH +: ELEM_WIDTH] = ELEM_WIDTH'(base + i);
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; va = 0; vd = 0; vk = 0; ra = 1; rd = 1; rk = 1; x = '0;
        repeat (2) @(negedge clk);
        n_total++; if (a_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", a_valid); else n_pass++;
        n_total++; if (a_data !== 32'd0) $display("FAIL reset_data: got %0d expected 0", a_data); else n_pass++;
        n_total++; if (a_rank !== 4'd0) $display("FAIL reset_rank: got %0d expected 0", a_rank); else n_pass++;
        n_total++; if (a_last !== 1'b0) $display("FAIL reset_last: got %0b expected 0", a_last); else n_pass++;
        n_total++; if (a_ovf !== 1'b0) $display("FAIL reset_overflow: got %0b expected 0", a_ovf); else n_pass++;
        n_total++; if (a_iready !== 1'b1) $display("FAIL reset_iready: got %0b expected 1", a_iready); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_asc();
        x = vec(100); va = 1; ra = 1;
        @(negedge clk);
        va = 0;
        for (int r = 0; r < 4; r++) begin
            n_total++; if (a_valid !== 1'b1) $display("FAIL asc_valid r%0d: got %0b expected 1", r, a_valid); else n_pass++;
            n_total++; if (a_data !== 32'(115 - r)) $display("FAIL asc_data r%0d: got %0d expected %0d", r, a_data, 115 - r); else n_pass++;
            n_total++; if (a_rank !== 4'(r)) $display("FAIL asc_rank r%0d: got %0d expected %0d", r, a_rank, r); else n_pass++;
            n_total++; if (a_last !== (r == 3)) $display("FAIL asc_last r%0d: got %0b expected %0b", r, a_last, r == 3); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (a_valid !== 1'b0) $display("FAIL asc_end_valid: got %0b expected 0", a_valid); else n_pass++;
    endtask

    task automatic test_single_desc();
        x = vec(100); vd = 1; rd = 1;
        @(negedge clk);
        vd = 0;
        for (int r = 0; r < 4; r++) begin
            n_total++; if (d_data !== 32'(100 + r)) $display("FAIL desc_data r%0d: got %0d expected %0d", r, d_data, 100 + r); else n_pass++;
            n_total++; if (d_rank !== 4'(r)) $display("FAIL desc_rank r%0d: got %0d expected %0d", r, d_rank, r); else n_pass++;
            n_total++; if (d_last !== (r == 3)) $display("FAIL desc_last r%0d: got %0b expected %0b", r, d_last, r == 3); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (d_valid !== 1'b0) $display("FAIL desc_end_valid: got %0b expected 0", d_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        x = vec(100); va = 1; ra = 1;
        @(negedge clk);
        va = 0;
        n_total++; if (a_data !== 32'd115) $display("FAIL bp_r0_data: got %0d expected 115", a_data); else n_pass++;
        @(negedge clk);
        ra = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++; if (a_valid !== 1'b1) $display("FAIL bp_hold_valid c%0d: got %0b expected 1", k, a_valid); else n_pass++;
            n_total++; if (a_data !== 32'd114) $display("FAIL bp_hold_data c%0d: got %0d expected 114", k, a_data); else n_pass++;
            n_total++; if (a_rank !== 4'd1) $display("FAIL bp_hold_rank c%0d: got %0d expected 1", k, a_rank); else n_pass++;
        end
        ra = 1;
        for (int r = 1; r < 4; r++) begin
            n_total++; if (a_data !== 32'(115 - r)) $display("FAIL bp_resume_data r%0d: got %0d expected %0d", r, a_data, 115 - r); else n_pass++;
            n_total++; if (a_rank !== 4'(r)) $display("FAIL bp_resume_rank r%0d: got %0d expected %0d", r, a_rank, r); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (a_valid !== 1'b0) $display("FAIL bp_end_valid: got %0b expected 0", a_valid); else n_pass++;
    endtask

    task automatic test_overflow_drop();
        ra = 0;
        x = vec(100); va = 1; @(negedge clk);
        x = vec(200); va = 1; @(negedge clk);
        x = vec(300); va = 1; @(negedge clk);
        va = 0;
        n_total++; if (a_ovf !== 1'b1) $display("FAIL drop_overflow: got %0b expected 1", a_ovf); else n_pass++;
        n_total++; if (a_iready !== 1'b0) $display("FAIL drop_iready_full: got %0b expected 0", a_iready); else n_pass++;
        ra = 1;
        for (int e = 0; e < 8; e++) begin
            int expd;
            expd = ((e < 4) ? 100 : 200) + 15 - (e % 4);
            n_total++; if (a_valid !== 1'b1) $display("FAIL drop_valid e%0d: got %0b expected 1", e, a_valid); else n_pass++;
            n_total++; if (a_data !== 32'(expd)) $display("FAIL drop_data e%0d: got %0d expected %0d", e, a_data, expd); else n_pass++;
            n_total++; if (a_last !== ((e % 4) == 3)) $display("FAIL drop_last e%0d: got %0b expected %0b", e, a_last, (e % 4) == 3); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (a_valid !== 1'b0) $display("FAIL drop_end_valid: got %0b expected 0", a_valid); else n_pass++;
        n_total++; if (a_ovf !== 1'b1) $display("FAIL drop_sticky: got %0b expected 1", a_ovf); else n_pass++;
        n_total++; if (a_iready !== 1'b1) $display("FAIL drop_iready_empty: got %0b expected 1", a_iready); else n_pass++;
    endtask

    task automatic test_reset_mid();
        x = vec(100); va = 1; ra = 1;
        @(negedge clk);
        va = 0;
        repeat (2) @(negedge clk);
        n_total++; if (a_rank !== 4'd2) $display("FAIL rmid_pre_rank: got %0d expected 2", a_rank); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (a_valid !== 1'b0) $display("FAIL rmid_valid: got %0b expected 0", a_valid); else n_pass++;
        n_total++; if (a_data !== 32'd0) $display("FAIL rmid_data: got %0d expected 0", a_data); else n_pass++;
        n_total++; if (a_rank !== 4'd0) $display("FAIL rmid_rank: got %0d expected 0", a_rank); else n_pass++;
        n_total++; if (a_ovf !== 1'b0) $display("FAIL rmid_overflow: got %0b expected 0", a_ovf); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        x = vec(500); va = 1;
        @(negedge clk);
        va = 0;
        n_total++; if (a_valid !== 1'b1) $display("FAIL rmid_fresh_valid: got %0b expected 1", a_valid); else n_pass++;
        n_total++; if (a_data !== 32'd515) $display("FAIL rmid_fresh_data: got %0d expected 515", a_data); else n_pass++;
        n_total++; if (a_rank !== 4'd0) $display("FAIL rmid_fresh_rank: got %0d expected 0", a_rank); else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_overflow_accept();
        ra = 0;
        x = vec(100); va = 1; @(negedge clk);
        x = vec(200); va = 1; @(negedge clk);
        va = 0; ra = 1;
        for (int e = 0; e < 12; e++) begin
            int expd;
            expd = ((e < 4) ? 100 : (e < 8) ? 200 : 300) + 15 - (e % 4);
            n_total++; if (a_data !== 32'(expd)) $display("FAIL acc_data e%0d: got %0d expected %0d", e, a_data, expd); else n_pass++;
            n_total++; if (a_rank !== 4'(e % 4)) $display("FAIL acc_rank e%0d: got %0d expected %0d", e, a_rank, e % 4); else n_pass++;
            if (e == 3) begin x = vec(300); va = 1; end else va = 0;
            @(negedge clk);
        end
        n_total++; if (a_valid !== 1'b0) $display("FAIL acc_end_valid: got %0b expected 0", a_valid); else n_pass++;
        n_total++; if (a_ovf !== 1'b0) $display("FAIL acc_overflow: got %0b expected 0", a_ovf); else n_pass++;
    endtask

    task automatic test_back_to_back();
        ra = 1;
        x = vec(100); va = 1;
        @(negedge clk);
        for (int e = 0; e < 12; e++) begin
            int expd;
            expd = ((e < 4) ? 100 : (e < 8) ? 200 : 300) + 15 - (e % 4);
            n_total++; if (a_valid !== 1'b1) $display("FAIL b2b_valid e%0d: got %0b expected 1", e, a_valid); else n_pass++;
            n_total++; if (a_data !== 32'(expd)) $display("FAIL b2b_data e%0d: got %0d expected %0d", e, a_data, expd); else n_pass++;
            n_total++; if (a_last !== ((e % 4) == 3)) $display("FAIL b2b_last e%0d: got %0b expected %0b", e, a_last, (e % 4) == 3); else n_pass++;
            va = 0;
            if (e == 3) begin x = vec(200); va = 1; end
            if (e == 7) begin x = vec(300); va = 1; end
            @(negedge clk);
        end
        n_total++; if (a_valid !== 1'b0) $display("FAIL b2b_end_valid: got %0b expected 0", a_valid); else n_pass++;
        n_total++; if (a_ovf !== 1'b0) $display("FAIL b2b_overflow: got %0b expected 0", a_ovf); else n_pass++;
    endtask

    task automatic test_topk1();
        rk = 1;
        x = vec(100); vk = 1; @(negedge clk);
        for (int e = 0; e < 3; e++) begin
            n_total++; if (k_valid !== 1'b1) $display("FAIL k1_valid e%0d: got %0b expected 1", e, k_valid); else n_pass++;
            n_total++; if (k_data !== 32'(100 * (e + 1) + 15)) $display("FAIL k1_data e%0d: got %0d expected %0d", e, k_data, 100 * (e + 1) + 15); else n_pass++;
            n_total++; if (k_last !== 1'b1) $display("FAIL k1_last e%0d: got %0b expected 1", e, k_last); else n_pass++;
            n_total++; if (k_rank !== 4'd0) $display("FAIL k1_rank e%0d: got %0d expected 0", e, k_rank); else n_pass++;
            if (e < 2) begin x = vec(100 * (e + 2)); vk = 1; end else vk = 0;
            @(negedge clk);
        end
        n_total++; if (k_valid !== 1'b0) $display("FAIL k1_end_valid: got %0b expected 0", k_valid); else n_pass++;
        n_total++; if (k_ovf !== 1'b0) $display("FAIL k1_overflow: got %0b expected 0", k_ovf); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single_asc();
        test_single_desc();
        test_backpressure();
        test_overflow_drop();
        test_reset_mid();
        test_overflow_accept();
        test_back_to_back();
        test_topk1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
